regfile_wb_scheduler: RTL and testbench

//  Scoreboard plus write-port arbiter for the 32x32 integer register file.

---
 rtl/regfile_wb_scheduler_if.sv | 52 +++++
 rtl/regfile_wb_scheduler.sv | 94 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of issue, writeback and register-file write-port signals for the
// register-file writeback scheduler.
//   master : drives issue/flush and both writeback requests, and receives
//            issue_ready, the writeback grants and the rf write port
//   slave  : the scheduler side of the same signals
interface regfile_wb_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  // Issue / hazard check
  logic                  issue_valid;
  logic [IDX_W-1:0]      issue_rs1;
  logic [IDX_W-1:0]      issue_rs2;
  logic [IDX_W-1:0]      issue_rd;
  logic                  issue_ready;
  logic                  flush;

  // Writeback source 0: main pipeline
  logic                  wb0_valid;
  logic [IDX_W-1:0]      wb0_rd;
  logic [DATA_WIDTH-1:0] wb0_data;
  logic                  wb0_ready;

  // Writeback source 1: long-latency unit
  logic                  wb1_valid;
  logic [IDX_W-1:0]      wb1_rd;
  logic [DATA_WIDTH-1:0] wb1_data;
  logic                  wb1_ready;

  // Register-file write port
  logic                  rf_load;
  logic [IDX_W-1:0]      rf_rd;
  logic [DATA_WIDTH-1:0] rf_in;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, flush,
    output wb0_valid, wb0_rd, wb0_data,
    output wb1_valid, wb1_rd, wb1_data,
    input  issue_ready, wb0_ready, wb1_ready,
    input  rf_load, rf_rd, rf_in
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, flush,
    input  wb0_valid, wb0_rd, wb0_data,
    input  wb1_valid, wb1_rd, wb1_data,
    output issue_ready, wb0_ready, wb1_ready,
    output rf_load, rf_rd, rf_in
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Scoreboard and write-port arbiter for the integer register file.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of regfile_wb_scheduler_if
//     issue_*   : hazard check for the decoded instruction (issue_ready is comb)
//     flush     : clears the scoreboard, suppresses a same-cycle issue
//     wb0_*     : main-pipeline writeback request / grant
//     wb1_*     : long-latency-unit writeback request / grant
//     rf_*      : register-file write port, combinational from the grant
module regfile_wb_scheduler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_wb_scheduler_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  // busy: register has an outstanding write; rr_last: 1 = wb1 won last contention
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  rr_last_q, rr_last_d;

  logic                  contend_c;
  logic                  grant0_c;
  logic                  grant1_c;
  logic                  grant_any_c;
  logic [IDX_W-1:0]      grant_rd_c;
  logic [DATA_WIDTH-1:0] grant_data_c;
  logic                  issue_ready_c;
  logic                  issue_fire_c;

  // Round-robin arbitration; a lone requester always wins.
  always_comb begin
    contend_c    = bus.wb0_valid & bus.wb1_valid;
    grant0_c     = bus.wb0_valid & (~bus.wb1_valid |  rr_last_q);
    grant1_c     = bus.wb1_valid & (~bus.wb0_valid | ~rr_last_q);
    grant_any_c  = grant0_c | grant1_c;
    grant_rd_c   = '0;
    grant_data_c = '0;
    if (grant0_c) begin
      grant_rd_c   = bus.wb0_rd;
      grant_data_c = bus.wb0_data;
    end else if (grant1_c) begin
      grant_rd_c   = bus.wb1_rd;
      grant_data_c = bus.wb1_data;
    end
  end

  // Hazard check covers RAW on both sources and WAW on the destination.
  always_comb begin
    issue_ready_c = ~(busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2] |
                      busy_q[bus.issue_rd]);
    issue_fire_c  = bus.issue_valid & issue_ready_c & ~bus.flush;
  end

  // Write port and handshake outputs; x0 writes are acknowledged but never load.
  assign bus.issue_ready = issue_ready_c;
  assign bus.wb0_ready   = grant0_c;
  assign bus.wb1_ready   = grant1_c;
  assign bus.rf_load     = grant_any_c & (grant_rd_c != '0);
  assign bus.rf_rd       = grant_rd_c;
  assign bus.rf_in       = grant_data_c;

  // Next state: clear applied before set so a same-edge issue to rd wins.
  always_comb begin
    busy_d    = busy_q;
    rr_last_d = rr_last_q;
    if (contend_c) begin
      rr_last_d = grant1_c;
    end
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (grant_any_c) begin
        busy_d[grant_rd_c] = 1'b0;
      end
      if (issue_fire_c) begin
        busy_d[bus.issue_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers; rr_last resets to wb1 so wb0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      rr_last_q <= 1'b1;
    end else begin
      busy_q    <= busy_d;
      rr_last_q <= rr_last_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a scoreboard/arbiter reference model.
module tb_regfile_wb_scheduler;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bus ();

  regfile_wb_scheduler #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_busy [NR];
  int m_last;      // source that won the last contention
  int last_g;      // grant seen in the most recent cycle (-1 = none)

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last = 1;
  endfunction

  function automatic int exp_grant();
    if (bus.wb0_valid && bus.wb1_valid) return 1 - m_last;
    if (bus.wb0_valid) return 0;
    if (bus.wb1_valid) return 1;
    return -1;
  endfunction

  function automatic bit exp_ready();
    return !(m_busy[bus.issue_rs1] || m_busy[bus.issue_rs2] || m_busy[bus.issue_rd]);
  endfunction

  task automatic check_outputs();
    int g;
    logic [4:0]  erd;
    logic [31:0] edat;
    g    = exp_grant();
    erd  = (g == 0) ? bus.wb0_rd   : (g == 1) ? bus.wb1_rd   : 5'd0;
    edat = (g == 0) ? bus.wb0_data : (g == 1) ? bus.wb1_data : 32'd0;
    chk("issue_ready", 64'(bus.issue_ready), 64'(exp_ready()));
    chk("wb0_ready",   64'(bus.wb0_ready),   64'(g == 0));
    chk("wb1_ready",   64'(bus.wb1_ready),   64'(g == 1));
    chk("rf_load",     64'(bus.rf_load),     64'(g >= 0 && erd != 5'd0));
    chk("rf_rd",       64'(bus.rf_rd),       64'(erd));
    chk("rf_in",       64'(bus.rf_in),       64'(edat));
  endtask

  // One clock: check at negedge, then advance the model across the posedge.
  task automatic cycle();
    int g;
    bit fire;
    logic [4:0] erd;
    @(negedge clk);
    check_outputs();
    g    = exp_grant();
    erd  = (g == 0) ? bus.wb0_rd : bus.wb1_rd;
    fire = bus.issue_valid && exp_ready() && !bus.flush;
    @(posedge clk);
    if (bus.wb0_valid && bus.wb1_valid) m_last = g;
    if (bus.flush) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      if (g >= 0) m_busy[erd] = 1'b0;
      if (fire && bus.issue_rd != 5'd0) m_busy[bus.issue_rd] = 1'b1;
    end
    last_g = g;
    #1;
  endtask

  task automatic set_issue(input bit v, input int rs1, input int rs2, input int rd);
    bus.issue_valid = v;
    bus.issue_rs1   = 5'(rs1);
    bus.issue_rs2   = 5'(rs2);
    bus.issue_rd    = 5'(rd);
  endtask

  task automatic idle_wb();
    bus.wb0_valid = 1'b0; bus.wb0_rd = '0; bus.wb0_data = '0;
    bus.wb1_valid = 1'b0; bus.wb1_rd = '0; bus.wb1_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_issue(0, 0, 0, 0);
    bus.flush = 1'b0;
    idle_wb();
    model_reset();
    last_g = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb0_ready", 64'(bus.wb0_ready), 64'd0);
    chk("rst_wb1_ready", 64'(bus.wb1_ready), 64'd0);
    chk("rst_rf_load",   64'(bus.rf_load),   64'd0);
    chk("rst_rf_rd",     64'(bus.rf_rd),     64'd0);
    chk("rst_rf_in",     64'(bus.rf_in),     64'd0);
    chk("rst_ready",     64'(bus.issue_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int probe [4];

    // T1: RAW stall then release after writeback
    do_reset();
    set_issue(1, 0, 0, 5); cycle();
    set_issue(0, 5, 0, 0); #1;
    chk("t1_stall", 64'(bus.issue_ready), 64'd0);
    bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd5; bus.wb0_data = 32'hDEADBEEF; #1;
    chk("t1_load", 64'(bus.rf_load), 64'd1);
    chk("t1_rd",   64'(bus.rf_rd),   64'd5);
    chk("t1_in",   64'(bus.rf_in),   64'hDEADBEEF);
    chk("t1_still_stall", 64'(bus.issue_ready), 64'd0);
    cycle();
    idle_wb(); #1;
    chk("t1_ready", 64'(bus.issue_ready), 64'd1);
    cycle();

    // T2: sustained contention alternates starting with wb0
    do_reset();
    bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd3; bus.wb0_data = 32'h0000_0303;
    bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd4; bus.wb1_data = 32'h0000_0404;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_wb0", 64'(bus.wb0_ready), 64'(i % 2 == 0));
      chk("t2_wb1", 64'(bus.wb1_ready), 64'(i % 2 == 1));
      chk("t2_one_hot", 64'(bus.wb0_ready + bus.wb1_ready), 64'd1);
      cycle();
    end

    // T3: write to x0 is acknowledged but does not load
    idle_wb();
    bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd0; bus.wb1_data = 32'h1234; #1;
    chk("t3_ready", 64'(bus.wb1_ready), 64'd1);
    chk("t3_load",  64'(bus.rf_load),   64'd0);
    cycle();
    idle_wb();

    // T4: same-edge issue and writeback to rd=7, set wins
    do_reset();
    set_issue(1, 0, 0, 7);
    bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd7; bus.wb0_data = 32'hCAFE_0007; #1;
    chk("t4_load", 64'(bus.rf_load), 64'd1);
    cycle();
    idle_wb();
    set_issue(1, 0, 7, 0); #1;
    chk("t4_stall", 64'(bus.issue_ready), 64'd0);
    cycle();

    // T5: flush clears scoreboard and drops the concurrent issue
    do_reset();
    set_issue(1, 0, 0, 2);  cycle();
    set_issue(1, 0, 0, 9);  cycle();
    set_issue(1, 0, 0, 31); cycle();
    set_issue(0, 9, 0, 0); #1;
    chk("t5_pre", 64'(bus.issue_ready), 64'd0);
    bus.flush = 1'b1;
    set_issue(1, 0, 0, 12); cycle();
    bus.flush = 1'b0;
    probe[0] = 2; probe[1] = 9; probe[2] = 31; probe[3] = 12;
    foreach (probe[k]) begin
      set_issue(0, probe[k], 0, 0); #1;
      chk("t5_clear", 64'(bus.issue_ready), 64'd1);
    end
    cycle();

    // T6: mid-cycle async reset clears busy before the next edge
    do_reset();
    set_issue(1, 0, 0, 6); cycle();
    set_issue(0, 6, 0, 0); #1;
    chk("t6_busy", 64'(bus.issue_ready), 64'd0);
    rst = 1'b1; #1;
    model_reset();
    chk("t6_async", 64'(bus.issue_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd1; bus.wb0_data = 32'h11;
    bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd2; bus.wb1_data = 32'h22; #1;
    chk("t6_wb0_first", 64'(bus.wb0_ready), 64'd1);
    chk("t6_wb1_wait",  64'(bus.wb1_ready), 64'd0);
    cycle();
    idle_wb();

    // Randomized traffic; sources hold their request until granted
    do_reset();
    for (int n = 0; n < 600; n++) begin
      set_issue($urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7));
      bus.flush = ($urandom_range(0, 29) == 0);
      if (!bus.wb0_valid || last_g == 0) begin
        bus.wb0_valid = $urandom_range(0, 1) == 1;
        bus.wb0_rd    = 5'($urandom_range(0, 7));
        bus.wb0_data  = $urandom;
      end
      if (!bus.wb1_valid || last_g == 1) begin
        bus.wb1_valid = $urandom_range(0, 2) == 0;
        bus.wb1_rd    = 5'($urandom_range(0, 7));
        bus.wb1_data  = $urandom;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
